// File: rtl/multisim_packer_pkg.sv
// Shared types and helpers for the multisim push packer.
package multisim_packer_pkg;

  // Assembly FSM: FILL accepts beats, HOLD parks a finished word while the
  // output slot is still occupied.
  typedef enum logic [0:0] {
    PK_FILL = 1'b0,
    PK_HOLD = 1'b1
  } packer_state_e;

  // Width of the beat-count field that tags each packed word (1..beats).
  function automatic int pk_cnt_w(input int beats);
    return $clog2(beats + 1);
  endfunction

endpackage

// File: rtl/multisim_pack_slot.sv
// Output holding register for the packer: one word with valid/ready.
// A word is only loaded while the slot is free, so the held word never
// changes under backpressure.
module multisim_pack_slot #(
  parameter int WIDTH = 67
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic             free
);

  // The slot can take a new word when it is empty or being drained this cycle.
  assign free = !out_vld || out_rdy;

  // Load replaces the word (valid stays high); a drain with no load empties it.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_data <= '0;
    end else if (load) begin
      out_vld  <= 1'b1;
      out_data <= load_data;
    end else if (out_rdy) begin
      out_vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/multisim_push_packer.sv
// Stream packer feeding the multisim server push stage. Collects up to BEATS
// narrow beats into one wide word tagged with its beat count. One assembly
// register plus one output slot let the next word assemble while the current
// one waits on backpressure.
module multisim_push_packer
  import multisim_packer_pkg::*;
#(
  parameter  int IN_WIDTH  = 16,
  parameter  int BEATS     = 4,
  localparam int CNT_W     = pk_cnt_w(BEATS),
  localparam int OUT_WIDTH = CNT_W + IN_WIDTH * BEATS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [31:0]          words_out
);

  localparam int IDX_W = $clog2(BEATS);

  packer_state_e                      state;
  logic [IDX_W-1:0]                   idx;
  logic [BEATS-1:0][IN_WIDTH-1:0]     lanes;
  logic [BEATS-1:0][IN_WIDTH-1:0]     lanes_merged;
  logic [CNT_W-1:0]                   hold_cnt;
  logic [CNT_W-1:0]                   beat_cnt;
  logic                               beat_fire;
  logic                               completing;
  logic                               slot_free;
  logic                               slot_load;
  logic [OUT_WIDTH-1:0]               slot_data;

  // Ready is a pure decode of the state register, independent of in_vld.
  assign in_rdy     = (state == PK_FILL);
  assign beat_fire  = in_vld && in_rdy;
  assign completing = (idx == IDX_W'(BEATS - 1)) || in_last;
  assign beat_cnt   = CNT_W'(idx) + CNT_W'(1);

  // Assembly lanes with the incoming beat dropped into its lane.
  // NOTE: every always_comb output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    lanes_merged      = lanes;
    lanes_merged[idx] = in_data;
  end

  // Decide when a finished word moves into the output slot, and which word.
  always_comb begin
    slot_load = 1'b0;
    slot_data = '0;
    case (state)
      PK_FILL: begin
        if (beat_fire && completing && slot_free) begin
          slot_load = 1'b1;
          slot_data = {beat_cnt, lanes_merged};
        end
      end
      PK_HOLD: begin
        if (slot_free) begin
          slot_load = 1'b1;
          slot_data = {hold_cnt, lanes};
        end
      end
      default: begin
        slot_load = 1'b0;
      end
    endcase
  end

  // Assembly FSM: writes lanes, advances idx, parks a word in HOLD when the
  // slot is busy and releases it once the slot frees.
  // NOTE: the assembly lanes are reset to zero on purpose; unused lanes of a
  // short word must read as zero, and reset must discard any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PK_FILL;
      idx      <= '0;
      lanes    <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        PK_FILL: begin
          if (beat_fire) begin
            if (!completing) begin
              lanes <= lanes_merged;
              idx   <= idx + IDX_W'(1);
            end else if (slot_free) begin
              lanes <= '0;
              idx   <= '0;
            end else begin
              lanes    <= lanes_merged;
              hold_cnt <= beat_cnt;
              state    <= PK_HOLD;
            end
          end
        end
        PK_HOLD: begin
          if (slot_free) begin
            lanes <= '0;
            idx   <= '0;
            state <= PK_FILL;
          end
        end
        default: begin
          state <= PK_FILL;
        end
      endcase
    end
  end

  // Count output handshakes; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_out <= '0;
    end else if (out_vld && out_rdy) begin
      words_out <= words_out + 32'd1;
    end
  end

  multisim_pack_slot #(
    .WIDTH (OUT_WIDTH)
  ) u_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (slot_load),
    .load_data (slot_data),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .out_data  (out_data),
    .free      (slot_free)
  );

endmodule

// File: tb/tb_multisim_push_packer.sv
// Self-checking bench for multisim_push_packer: a queue-based model of the
// packing and buffering rules checked every cycle, plus literal expectations.
module tb_multisim_push_packer;

  localparam int IN_WIDTH  = 16;
  localparam int BEATS     = 4;
  localparam int CNT_W     = 3;
  localparam int OUT_WIDTH = CNT_W + IN_WIDTH * BEATS;

  logic                 clk;
  logic                 rst_n;
  logic                 in_vld;
  logic                 in_rdy;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_last;
  logic                 out_vld;
  logic                 out_rdy;
  logic [OUT_WIDTH-1:0] out_data;
  logic [31:0]          words_out;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  bit rand_rdy   = 0;
  bit collecting = 0;
  logic [OUT_WIDTH-1:0] rx_q[$];

  multisim_push_packer #(
    .IN_WIDTH (IN_WIDTH),
    .BEATS    (BEATS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .out_data  (out_data),
    .words_out (words_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Build a packed word from a list of beats: beat k in lane k, count on top.
  function automatic logic [OUT_WIDTH-1:0] pack_word(input logic [IN_WIDTH-1:0] b[$]);
    logic [OUT_WIDTH-1:0] w;
    w = '0;
    foreach (b[k]) w[k*IN_WIDTH +: IN_WIDTH] = b[k];
    w[OUT_WIDTH-1 -: CNT_W] = CNT_W'(b.size());
    return w;
  endfunction

  // Model: a list of beats being gathered and a queue of finished words not yet
  // delivered. At most two finished words can be buffered; input is ready
  // whenever fewer than two are waiting.
  logic [IN_WIDTH-1:0]  m_part[$];
  logic [OUT_WIDTH-1:0] m_pend[$];
  logic [31:0]          m_words = '0;
  bit                   m_take;
  bit                   m_xfer;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_part.delete();
      m_pend.delete();
      m_words = '0;
    end else begin
      m_xfer = (m_pend.size() > 0) && out_rdy;
      m_take = in_vld && (m_pend.size() < 2);
      if (m_xfer) begin
        void'(m_pend.pop_front());
        m_words = m_words + 32'd1;
      end
      if (m_take) begin
        m_part.push_back(in_data);
        if (in_last || m_part.size() == BEATS) begin
          m_pend.push_back(pack_word(m_part));
          m_part.delete();
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("in_rdy", in_rdy, m_pend.size() < 2);
    check("out_vld", out_vld, m_pend.size() > 0);
    check("words_out", words_out, m_words);
    if (m_pend.size() > 0) check("out_data", out_data, m_pend[0]);
  end

  // Random downstream stalls for the integration run.
  always @(negedge clk) begin
    if (rand_rdy) out_rdy = 1'($urandom_range(0, 1));
  end

  // Downstream receiver: records every word handed over.
  always @(posedge clk) begin
    if (collecting && rst_n && out_vld && out_rdy) rx_q.push_back(out_data);
  end

  // Offer one beat (called at a negedge); returns at the negedge after acceptance.
  task automatic send(input logic [IN_WIDTH-1:0] d, input logic l);
    bit done;
    done    = 0;
    in_vld  = 1'b1;
    in_data = d;
    in_last = l;
    for (int n = 0; n < 200 && !done; n++) begin
      done = in_rdy;
      @(negedge clk);
    end
    check("beat_accepted", done, 1'b1);
  endtask

  task automatic idle();
    in_vld  = 1'b0;
    in_last = 1'b0;
  endtask

  logic [IN_WIDTH-1:0]  vd[30];
  bit                   vl[30];
  logic [OUT_WIDTH-1:0] exp_q[$];
  logic [IN_WIDTH-1:0]  tmp_part[$];
  int                   c0;

  initial begin
    rst_n   = 1'b0;
    in_vld  = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    out_rdy = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_in_rdy", in_rdy, 1'b1);
    check("rst_out_vld", out_vld, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_words", words_out, 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Full word.
    send(16'h1111, 1'b0);
    send(16'h2222, 1'b0);
    send(16'h3333, 1'b0);
    send(16'h4444, 1'b0);
    check("full_vld", out_vld, 1'b1);
    check("full_word", out_data, {3'd4, 64'h4444_3333_2222_1111});
    idle();
    @(negedge clk);
    check("full_words_out", words_out, 32'd1);

    // Early last, then a word that must start again in lane 0.
    send(16'hAAAA, 1'b0);
    send(16'hBBBB, 1'b1);
    check("early_word", out_data, {3'd2, 64'h0000_0000_BBBB_AAAA});
    send(16'hCCCC, 1'b1);
    check("lane0_word", out_data, {3'd1, 64'h0000_0000_0000_CCCC});
    idle();
    @(negedge clk);
    check("early_words_out", words_out, 32'd3);

    // Single-beat words back to back.
    c0 = cyc;
    for (int i = 0; i < 8; i++) send(IN_WIDTH'(16'h0A00 + i), 1'b1);
    check("single_cycles", cyc - c0, 8);
    check("single_last_word", out_data, {3'd1, 64'h0000_0000_0000_0A07});
    idle();
    @(negedge clk);
    check("single_words_out", words_out, 32'd11);

    // Backpressure: 12 beats with the downstream stalled.
    out_rdy = 1'b0;
    for (int i = 1; i <= 8; i++) send(IN_WIDTH'(16'h0100 + i), 1'b0);
    check("bp_in_rdy_low", in_rdy, 1'b0);
    check("bp_word1", out_data, {3'd4, 64'h0104_0103_0102_0101});
    fork
      begin
        for (int i = 9; i <= 12; i++) send(IN_WIDTH'(16'h0100 + i), 1'b0);
        idle();
      end
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("bp_hold_word1", out_data, {3'd4, 64'h0104_0103_0102_0101});
          check("bp_hold_rdy", in_rdy, 1'b0);
        end
        out_rdy = 1'b1;
      end
    join
    repeat (3) @(negedge clk);
    check("bp_words_out", words_out, 32'd14);

    // Reset in the middle of a word.
    send(16'hE001, 1'b0);
    send(16'hE002, 1'b0);
    idle();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_vld", out_vld, 1'b0);
    check("midrst_words", words_out, 32'd0);
    check("midrst_in_rdy", in_rdy, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    send(16'hD001, 1'b0);
    send(16'hD002, 1'b0);
    send(16'hD003, 1'b0);
    send(16'hD004, 1'b0);
    check("postrst_word", out_data, {3'd4, 64'hD004_D003_D002_D001});
    idle();
    @(negedge clk);
    check("postrst_words", words_out, 32'd1);

    // Integration with a stalling downstream: every word once, in order.
    for (int i = 0; i < 30; i++) begin
      vd[i] = IN_WIDTH'(16'h5000 + i);
      vl[i] = (i % 5 == 2) || (i % 7 == 6) || (i == 29);
    end
    tmp_part.delete();
    for (int i = 0; i < 30; i++) begin
      tmp_part.push_back(vd[i]);
      if (vl[i] || tmp_part.size() == BEATS) begin
        exp_q.push_back(pack_word(tmp_part));
        tmp_part.delete();
      end
    end
    rx_q.delete();
    collecting = 1;
    rand_rdy   = 1;
    for (int i = 0; i < 30; i++) send(vd[i], vl[i]);
    idle();
    for (int n = 0; n < 300 && rx_q.size() < exp_q.size(); n++) @(negedge clk);
    rand_rdy = 0;
    @(negedge clk);
    out_rdy = 1'b1;
    collecting = 0;
    check("integ_count", rx_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < rx_q.size()) check("integ_word", rx_q[i], exp_q[i]);
    end
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
